// File: rtl/pb_debounce_pkg.sv
// Shared types and defaults for the pushbutton debouncer.
// Optional long-press detection is enabled with PB_DEBOUNCE_LONGPRESS_EN.
package pb_debounce_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } deb_state_e;

    localparam int   DEF_N_BTN         = 2;
    localparam int   DEF_CNT_W         = 20;
    localparam int   DEF_STABLE_CYCLES = 500000;
    localparam int   DEF_LONG_CYCLES   = 100000000;
    localparam logic DEF_IDLE_LEVEL    = 1'b1;

    // Bits needed to hold any value in 0..max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/pb_debounce_chan.sv
// One debounce channel: 2-flop synchroniser, stability FSM, press/release strobes.
// With PB_DEBOUNCE_LONGPRESS_EN a saturating hold counter drives o_long_press.
module pb_debounce_chan
    import pb_debounce_pkg::*;
#(
    parameter int   CNT_W         = DEF_CNT_W,
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter logic IDLE_LEVEL    = DEF_IDLE_LEVEL
`ifdef PB_DEBOUNCE_LONGPRESS_EN
    ,
    parameter int   LONG_CYCLES   = DEF_LONG_CYCLES
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_btn_raw,
    output logic o_btn_clean,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_clean;
    logic             r_press;
    logic             r_release;
    deb_state_e       r_state;
    deb_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= IDLE_LEVEL;
            r_sync2   <= IDLE_LEVEL;
            r_clean   <= IDLE_LEVEL;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_state   <= STABLE;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn_raw;
            r_sync2   <= r_sync1;
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            if (w_accept) begin
                r_clean <= r_sync2;
            end
            r_press   <= w_accept && (r_sync2 != IDLE_LEVEL);
            r_release <= w_accept && (r_sync2 == IDLE_LEVEL);
        end
    end

    // Any return of sync2 to the accepted level drops back to STABLE, so a bounce restarts the count.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        w_accept     = 1'b0;
        case (r_state)
            STABLE: begin
                if (r_sync2 != r_clean) begin
                    w_state_next = CHECK;
                    w_cnt_next   = CNT_W'(1);
                end
            end
            CHECK: begin
                if (r_sync2 == r_clean) begin
                    w_state_next = STABLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_accept     = 1'b1;
                    w_state_next = STABLE;
                end else begin
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = STABLE;
            end
        endcase
    end

    assign o_btn_clean     = r_clean;
    assign o_press_pulse   = r_press;
    assign o_release_pulse = r_release;

`ifdef PB_DEBOUNCE_LONGPRESS_EN
    localparam int                HOLD_W   = cnt_width(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] r_hold;
    logic              r_long;
    logic              w_held;

    assign w_held = (r_clean != IDLE_LEVEL);

    // Accept covers both press (restart) and release (clear); saturation blocks a repeat strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= w_held && (r_hold == HOLD_PRE);
            if (w_accept) begin
                r_hold <= '0;
            end else if (w_held && (r_hold != HOLD_MAX)) begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    assign o_long_press = r_long;
`else
    assign o_long_press = 1'b0;
`endif

endmodule

// File: rtl/pushbutton_debounce.sv
// Debounces N_BTN active-low pushbuttons for the PIO in_port, with press/release strobes.
// Define PB_DEBOUNCE_LONGPRESS_EN to add LONG_CYCLES and the long_press strobe.
module pushbutton_debounce
    import pb_debounce_pkg::*;
#(
    parameter int   N_BTN         = DEF_N_BTN,
    parameter int   CNT_W         = DEF_CNT_W,
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter logic IDLE_LEVEL    = DEF_IDLE_LEVEL
`ifdef PB_DEBOUNCE_LONGPRESS_EN
    ,
    parameter int   LONG_CYCLES   = DEF_LONG_CYCLES
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_clean,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_press
);

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_chan
            pb_debounce_chan #(
                .CNT_W         (CNT_W),
                .STABLE_CYCLES (STABLE_CYCLES),
                .IDLE_LEVEL    (IDLE_LEVEL)
`ifdef PB_DEBOUNCE_LONGPRESS_EN
                ,
                .LONG_CYCLES   (LONG_CYCLES)
`endif
            ) u_chan (
                .clk             (clk),
                .reset_n         (reset_n),
                .i_btn_raw       (btn_raw[gi]),
                .o_btn_clean     (btn_clean[gi]),
                .o_press_pulse   (press_pulse[gi]),
                .o_release_pulse (release_pulse[gi]),
                .o_long_press    (long_press[gi])
            );
        end
    endgenerate

endmodule
